// File: rtl/div_pipe_ss.sv
// Fully pipelined restoring divider: one signed/unsigned divide per cycle, quotient and
// remainder after S+2 cycles, opaque tag carried alongside for writeback routing.
module div_pipe_ss #(
  parameter int WIDTH = 32,
  parameter int BPS   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int S = WIDTH / BPS;

  // Handshake: a request transfers on in_valid & in_ready, a result on out_valid & out_ready.
  // The whole pipe advances as one (adv) whenever the output slot is empty or being taken.
  logic adv;

  // Stored partial remainder is always < divisor, so WIDTH bits suffice between stages.
  logic             valid_q [0:S], valid_d [0:S];
  logic [WIDTH-1:0] rem_q   [0:S], rem_d   [0:S];
  logic [WIDTH-1:0] aq_q    [0:S], aq_d    [0:S];
  logic [WIDTH-1:0] raw_q   [0:S], raw_d   [0:S];
  logic             qneg_q  [0:S], qneg_d  [0:S];
  logic             rneg_q  [0:S], rneg_d  [0:S];
  logic             dbz_q   [0:S], dbz_d   [0:S];
  logic [TAG_W-1:0] tag_q   [0:S], tag_d   [0:S];
  logic [WIDTH-1:0] dvs_q   [0:S-1], dvs_d [0:S-1];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_dbz_q, out_dbz_d;

  logic             a_neg, b_neg, any_valid;
  logic [WIDTH-1:0] a_mag, b_mag;

  // BPS restoring steps, MSB first; dividend bits shift out of aq as quotient bits shift in.
  function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] aq,
                                                   input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] x;
    r = rem;
    x = aq;
    for (int i = 0; i < BPS; i++) begin
      t = {r, x[WIDTH-1]};
      x = {x[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, dvs}) begin
        t    = t - {1'b0, dvs};
        x[0] = 1'b1;
      end
      r = t[WIDTH-1:0];
    end
    return {r, x};
  endfunction

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_neg = in_signed && in_dividend[WIDTH-1];
    b_neg = in_signed && in_divisor[WIDTH-1];
    a_mag = a_neg ? -in_dividend : in_dividend;
    b_mag = b_neg ? -in_divisor : in_divisor;

    for (int k = 0; k <= S; k++) begin
      valid_d[k] = valid_q[k];
      rem_d[k]   = rem_q[k];
      aq_d[k]    = aq_q[k];
      raw_d[k]   = raw_q[k];
      qneg_d[k]  = qneg_q[k];
      rneg_d[k]  = rneg_q[k];
      dbz_d[k]   = dbz_q[k];
      tag_d[k]   = tag_q[k];
    end
    for (int k = 0; k < S; k++) dvs_d[k] = dvs_q[k];
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_tag_d   = out_tag_q;
    out_dbz_d   = out_dbz_q;

    if (adv) begin
      valid_d[0] = in_valid;
      rem_d[0]   = '0;
      aq_d[0]    = a_mag;
      dvs_d[0]   = b_mag;
      raw_d[0]   = in_dividend;
      qneg_d[0]  = a_neg ^ b_neg;
      rneg_d[0]  = a_neg;
      dbz_d[0]   = (in_divisor == '0);
      tag_d[0]   = in_tag;
      for (int k = 1; k <= S; k++) begin
        {rem_d[k], aq_d[k]} = div_steps(rem_q[k-1], aq_q[k-1], dvs_q[k-1]);
        if (k < S) dvs_d[k] = dvs_q[k-1];
        valid_d[k] = valid_q[k-1];
        raw_d[k]   = raw_q[k-1];
        qneg_d[k]  = qneg_q[k-1];
        rneg_d[k]  = rneg_q[k-1];
        dbz_d[k]   = dbz_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
      // MIN / -1 needs no special case: |MIN|/1 = 2^(WIDTH-1) with qneg clear reads back as MIN.
      out_valid_d = valid_q[S];
      if (valid_q[S]) begin
        out_tag_d = tag_q[S];
        out_dbz_d = dbz_q[S];
        if (dbz_q[S]) begin
          out_quo_d = '1;
          out_rem_d = raw_q[S];
        end else begin
          out_quo_d = qneg_q[S] ? -aq_q[S] : aq_q[S];
          out_rem_d = rneg_q[S] ? -rem_q[S] : rem_q[S];
        end
      end
    end

    if (flush) begin
      for (int k = 0; k <= S; k++) valid_d[k] = 1'b0;
      out_valid_d = 1'b0;
    end

    any_valid = out_valid_q;
    for (int k = 0; k <= S; k++) any_valid = any_valid || valid_q[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= S; k++) valid_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_tag_q   <= '0;
      out_dbz_q   <= 1'b0;
    end else begin
      for (int k = 0; k <= S; k++) valid_q[k] <= valid_d[k];
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_tag_q   <= out_tag_d;
      out_dbz_q   <= out_dbz_d;
    end
    for (int k = 0; k <= S; k++) begin
      rem_q[k]  <= rem_d[k];
      aq_q[k]   <= aq_d[k];
      raw_q[k]  <= raw_d[k];
      qneg_q[k] <= qneg_d[k];
      rneg_q[k] <= rneg_d[k];
      dbz_q[k]  <= dbz_d[k];
      tag_q[k]  <= tag_d[k];
    end
    for (int k = 0; k < S; k++) dvs_q[k] <= dvs_d[k];
  end

  assign out_valid     = out_valid_q;
  assign out_quotient  = out_quo_q;
  assign out_remainder = out_rem_q;
  assign out_tag       = out_tag_q;
  assign out_dbz       = out_dbz_q;
  assign busy          = any_valid;

endmodule

// File: tb/tb_div_pipe_ss.sv
// Directed and model-checked bench for div_pipe_ss: default 32/2 instance plus
// 8/1 and 16/4 instances sharing one stimulus port through a select.
module tb_div_pipe_ss;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int S  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_dividend = '0;
  logic [W-1:0]  in_divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_dbz, busy;
  logic [W-1:0]  out_quotient, out_remainder;
  logic [TW-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared stimulus for the small-width instances; sw_sel picks 8-bit (0) or 16-bit (1).
  logic          sw_sel = 1'b0, sw_in_valid = 1'b0, sw_signed = 1'b0;
  logic          sw_flush = 1'b0, sw_out_ready = 1'b1;
  logic [31:0]   sw_a = '0, sw_b = '0;
  logic [4:0]    sw_tag = '0;
  logic          d8_in_ready, d8_out_valid, d8_dbz, d8_busy;
  logic [7:0]    d8_q, d8_r;
  logic [4:0]    d8_tag;
  logic          d16_in_ready, d16_out_valid, d16_dbz, d16_busy;
  logic [15:0]   d16_q, d16_r;
  logic [4:0]    d16_tag;
  logic          sw_out_valid, sw_dbz, sw_busy, sw_in_ready;
  logic [31:0]   sw_q, sw_r;
  logic [4:0]    sw_otag;

  always #5 clk = ~clk;

  div_pipe_ss u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_tag(out_tag), .out_dbz(out_dbz), .busy(busy)
  );

  div_pipe_ss #(.WIDTH(8), .BPS(1), .TAG_W(5)) u_d8 (
    .clk(clk), .reset(reset), .flush(sw_flush),
    .in_valid(sw_in_valid & ~sw_sel), .in_ready(d8_in_ready), .in_signed(sw_signed),
    .in_dividend(sw_a[7:0]), .in_divisor(sw_b[7:0]), .in_tag(sw_tag),
    .out_valid(d8_out_valid), .out_ready(sw_out_ready),
    .out_quotient(d8_q), .out_remainder(d8_r),
    .out_tag(d8_tag), .out_dbz(d8_dbz), .busy(d8_busy)
  );

  div_pipe_ss #(.WIDTH(16), .BPS(4), .TAG_W(5)) u_d16 (
    .clk(clk), .reset(reset), .flush(sw_flush),
    .in_valid(sw_in_valid & sw_sel), .in_ready(d16_in_ready), .in_signed(sw_signed),
    .in_dividend(sw_a[15:0]), .in_divisor(sw_b[15:0]), .in_tag(sw_tag),
    .out_valid(d16_out_valid), .out_ready(sw_out_ready),
    .out_quotient(d16_q), .out_remainder(d16_r),
    .out_tag(d16_tag), .out_dbz(d16_dbz), .busy(d16_busy)
  );

  always_comb begin
    sw_out_valid = sw_sel ? d16_out_valid : d8_out_valid;
    sw_dbz       = sw_sel ? d16_dbz : d8_dbz;
    sw_busy      = sw_sel ? d16_busy : d8_busy;
    sw_in_ready  = sw_sel ? d16_in_ready : d8_in_ready;
    sw_q         = sw_sel ? {16'd0, d16_q} : {24'd0, d8_q};
    sw_r         = sw_sel ? {16'd0, d16_r} : {24'd0, d8_r};
    sw_otag      = sw_sel ? d16_tag : d8_tag;
  end

  // Reference: wide signed arithmetic, truncating toward zero, results masked to w bits.
  function automatic void ref_div(input int w, input logic sg, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
    longint sa, sb, lq, lr;
    logic [31:0] m;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    if (b == 32'd0) begin
      q = m; r = a; dz = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0] & m;
      r  = lr[31:0] & m;
      dz = 1'b0;
    end
  endfunction

  // Presents one request at a negedge with out_ready high; lat counts cycles from the
  // request cycle to the cycle out_valid is visible.
  task automatic run_single(input logic sg, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tg, output logic [31:0] q, output logic [31:0] r,
                            output logic [4:0] otg, output logic dz, output int lat,
                            output int busy_low);
    in_signed = sg; in_dividend = a; in_divisor = b; in_tag = tg; in_valid = 1'b1;
    out_ready = 1'b1;
    busy_low = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    q = out_quotient; r = out_remainder; otg = out_tag; dz = out_dbz;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_dividend = 32'd50; in_divisor = 32'd5; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient: got %h want 0", out_quotient); end
    n_checks++; if (out_remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder: got %h want 0", out_remainder); end
    n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_checks++; if (out_dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", out_dbz); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] q, r; logic [4:0] tg; logic dz; int lat, bl;
    run_single(1'b0, 32'd100, 32'd7, 5'd3, q, r, tg, dz, lat, bl);
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", r); end
    n_checks++; if (tg !== 5'd3) begin n_fail++; $display("FAIL basic_tag: got %0d want 3", tg); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", dz); end
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL basic_latency: got %0d want 18", lat); end
    n_checks++; if (bl != 0) begin n_fail++; $display("FAIL basic_busy: busy low %0d cycles, want 0", bl); end
    n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_drain: valid/busy %b want 00", {out_valid, busy}); end
  endtask

  logic        tv_s [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] tv_a [0:7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFF9};
  logic [31:0] tv_b [0:7] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2,
                              32'd0, 32'd0, 32'd1, 32'hFFFF_FFFE};
  logic [31:0] tv_q [0:7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
  logic [31:0] tv_r [0:7] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1,
                              32'd5, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF};
  logic        tv_z [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic test_signed_cases();
    logic [31:0] q, r; logic [4:0] tg; logic dz; int lat, bl;
    for (int i = 0; i < 8; i++) begin
      run_single(tv_s[i], tv_a[i], tv_b[i], 5'(i + 10), q, r, tg, dz, lat, bl);
      n_checks++;
      if ({q, r, tg, dz} !== {tv_q[i], tv_r[i], 5'(i + 10), tv_z[i]}) begin
        n_fail++;
        $display("FAIL vec%0d: got q=%h r=%h tag=%0d dbz=%b want q=%h r=%h tag=%0d dbz=%b",
                 i, q, r, tg, dz, tv_q[i], tv_r[i], i + 10, tv_z[i]);
      end
      n_checks++; if (lat != 18) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 18", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [69:0] exp_q[$];
    logic [69:0] got, held, e;
    logic [31:0] q, r;
    logic dz, stall_prev, have_op;
    int issued, recv, cyc;
    issued = 0; recv = 0; cyc = 0; stall_prev = 1'b0; have_op = 1'b0; held = '0;
    while (recv < 20 && cyc < 600) begin
      got = {out_quotient, out_remainder, out_tag, out_dbz};
      if (stall_prev && out_valid) begin
        n_checks++;
        if (got !== held) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", got, held); end
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got %h want no result", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL b2b_result%0d: got %h want %h", recv, got, e); end
        end
        recv++;
      end
      if (issued < 20) begin
        if (!have_op) begin
          in_signed   = 1'($urandom_range(0, 1));
          in_dividend = $urandom;
          in_divisor  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 9)) :
                        ($urandom_range(0, 1) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
          in_tag      = issued[4:0];
          have_op     = 1'b1;
        end
        in_valid = 1'b1;
        if (in_ready) begin
          ref_div(32, in_signed, in_dividend, in_divisor, q, r, dz);
          exp_q.push_back({q, r, in_tag, dz});
          issued++;
          have_op = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      stall_prev = out_valid && !out_ready;
      held = got;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv != 20) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 20", recv); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] q, r; logic [4:0] tg; logic dz; int lat, bl, seen;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_signed = 1'b0; in_dividend = 32'(1000 + i); in_divisor = 32'd3; in_tag = 5'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1; in_dividend = 32'd77; in_tag = 5'd20; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    seen = 0;
    repeat (S + 6) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_leak: got %0d results want 0", seen); end
    run_single(1'b0, 32'd1000, 32'd10, 5'd9, q, r, tg, dz, lat, bl);
    n_checks++;
    if ({q, r, tg, dz} !== {32'd100, 32'd0, 5'd9, 1'b0}) begin
      n_fail++; $display("FAIL flush_after: got q=%0d r=%0d tag=%0d dbz=%b want 100 0 9 0", q, r, tg, dz);
    end
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL flush_after_latency: got %0d want 18", lat); end
  endtask

  task automatic test_flush_stalled();
    int cyc;
    out_ready = 1'b0;
    in_signed = 1'b0; in_dividend = 32'd9; in_divisor = 32'd4; in_tag = 5'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({out_valid, in_ready, out_quotient, out_remainder} !== {1'b1, 1'b0, 32'd2, 32'd1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=2 r=1",
                 i, out_valid, in_ready, out_quotient, out_remainder);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL stall_flush: valid/busy %b want 00", {out_valid, busy});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    int seen;
    out_ready = 1'b1;
    in_signed = 1'b1; in_dividend = 32'hFFFF_FF00; in_divisor = 32'd16; in_tag = 5'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({out_valid, busy, out_quotient} !== {1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL mid_reset: got v=%b busy=%b q=%h want 0 0 0", out_valid, busy, out_quotient);
    end
    seen = 0;
    repeat (S + 6) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_leak: got %0d results want 0", seen); end
  endtask

  task automatic test_sweep(input logic sel, input int w, input int lat_exp, input int n_ops);
    logic [69:0] exp_q[$];
    logic [69:0] got, e;
    logic [31:0] m, mn, q, r;
    logic dz;
    int lat, bl, issued, recv, cyc;
    m  = (32'd1 << w) - 32'd1;
    mn = 32'd1 << (w - 1);
    sw_sel = sel;
    @(negedge clk);
    sw_signed = 1'b0; sw_a = m; sw_b = 32'd3; sw_tag = 5'd5; sw_in_valid = 1'b1;
    bl = 0;
    @(negedge clk);
    sw_in_valid = 1'b0;
    lat = 1;
    while (!sw_out_valid && lat < 100) begin
      if (!sw_busy) bl++;
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat != lat_exp) begin n_fail++; $display("FAIL sweep%0d_latency: got %0d want %0d", w, lat, lat_exp); end
    n_checks++; if (bl != 0) begin n_fail++; $display("FAIL sweep%0d_busy: busy low %0d cycles want 0", w, bl); end
    n_checks++;
    if ({sw_q, sw_r, sw_otag} !== {m / 32'd3, m % 32'd3, 5'd5}) begin
      n_fail++; $display("FAIL sweep%0d_first: got q=%h r=%h want q=%h r=%h", w, sw_q, sw_r, m / 32'd3, m % 32'd3);
    end
    @(negedge clk);
    issued = 0; recv = 0; cyc = 0;
    while (recv < n_ops && cyc < n_ops + 200) begin
      n_checks++; if (sw_in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_in_ready: got %b want 1", w, sw_in_ready); end
      if (sw_out_valid) begin
        got = {sw_q, sw_r, sw_otag, sw_dbz};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sweep%0d_extra: got %h want no result", w, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL sweep%0d_op%0d: got %h want %h", w, recv, got, e); end
        end
        recv++;
      end
      if (issued < n_ops) begin
        case (issued)
          0: begin sw_signed = 1'b1; sw_a = mn; sw_b = m;     end
          1: begin sw_signed = 1'b0; sw_a = m;  sw_b = 32'd1; end
          2: begin sw_signed = 1'b1; sw_a = mn; sw_b = 32'd0; end
          3: begin sw_signed = 1'b1; sw_a = m;  sw_b = mn;    end
          4: begin sw_signed = 1'b0; sw_a = 32'd0; sw_b = m;  end
          default: begin
            sw_signed = 1'($urandom_range(0, 1));
            sw_a = $urandom & m;
            sw_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : ($urandom & m);
          end
        endcase
        sw_tag = issued[4:0];
        sw_in_valid = 1'b1;
        ref_div(w, sw_signed, sw_a, sw_b, q, r, dz);
        exp_q.push_back({q, r, sw_tag, dz});
        issued++;
      end else begin
        sw_in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    sw_in_valid = 1'b0;
    n_checks++; if (recv != n_ops) begin n_fail++; $display("FAIL sweep%0d_timeout: got %0d results want %0d", w, recv, n_ops); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_cases();
    test_back_to_back();
    test_flush();
    test_flush_stalled();
    test_mid_reset();
    test_sweep(1'b0, 8, 10, 1500);
    test_sweep(1'b1, 16, 6, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
